bin2bcd_seq: RTL

Sequential binary-to-BCD converter that sits directly upstream of the 8-digit seven-segment display driver. It converts an unsigned binary value into eight packed BCD digits using iterative double-dabble, one bit per clock. Its `bcd` output drives the display's 32-bit `val` input, so counters and results appear in decimal instead of hex. Values that do not fit in eight decimal digits saturate and raise a flag.

---
 rtl/bin2bcd_pkg.sv | 16 +
 rtl/bin2bcd_seq_if.sv | 28 ++
 rtl/bcd_digit_adj.sv | 9 +
 rtl/bin2bcd_seq.sv | 99 +++++++++
 4 files changed

// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } b2b_state_t;

    localparam logic [3:0] BCD_NINE = 4'd9;

    // Enough decimal digits to hold any WIDTH-bit value (log10(2) ~ 0.301).
    function automatic int calc_idigits(input int width);
        return (width * 301) / 1000 + 1;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Request/result bundle between the converter and its user (e.g. the display driver).
import bin2bcd_pkg::*;

interface bin2bcd_seq_if #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 8
);
    // start/bin are sampled only on the edge where the converter is idle;
    // busy covers the conversion, done pulses once when bcd/ovf update.
    logic                  start;
    logic [WIDTH-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  ovf;
    b2b_state_t            dbg_state;

    modport master (
        output start, bin,
        input  busy, done, bcd, ovf, dbg_state
    );

    modport slave (
        input  start, bin,
        output busy, done, bcd, ovf, dbg_state
    );

endinterface

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
module bcd_digit_adj (
    input  logic [3:0] d_i,
    output logic [3:0] d_o
);

    assign d_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter, one input bit per clock,
// with saturation to all nines when the result exceeds DIGITS digits.
import bin2bcd_pkg::*;

module bin2bcd_seq #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    bin2bcd_seq_if.slave  bus
);

    localparam int IDIGITS = calc_idigits(WIDTH);
    localparam int SCR_W   = 4 * IDIGITS + WIDTH;
    localparam int CW      = $clog2(WIDTH + 1);

    b2b_state_t            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [SCR_W-1:0]      scratch_q, scratch_d;
    logic [4*DIGITS-1:0]   bcd_q, bcd_d;
    logic                  ovf_q, ovf_d;
    logic                  done_q, done_d;

    logic [4*IDIGITS-1:0]  adj_bcd;
    logic [SCR_W-1:0]      shifted;
    logic                  ovf_hit;

    for (genvar g = 0; g < IDIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .d_i (scratch_q[WIDTH + 4*g +: 4]),
            .d_o (adj_bcd[4*g +: 4])
        );
    end

    // The top digit can never reach 8, so dropping the adjusted MSB loses nothing.
    assign shifted = {adj_bcd[4*IDIGITS-2:0], scratch_q[WIDTH-1:0], 1'b0};

    always_comb begin
        ovf_hit = 1'b0;
        for (int i = DIGITS; i < IDIGITS; i++) begin
            ovf_hit = ovf_hit | (|shifted[WIDTH + 4*i +: 4]);
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        scratch_d = scratch_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    scratch_d = {{(4*IDIGITS){1'b0}}, bus.bin};
                    cnt_d     = CW'(WIDTH);
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                scratch_d = shifted;
                cnt_d     = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    ovf_d   = ovf_hit;
                    bcd_d   = ovf_hit ? {DIGITS{BCD_NINE}} : shifted[WIDTH +: 4*DIGITS];
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            scratch_q <= '0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            scratch_q <= scratch_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy      = (state_q == SHIFT);
    assign bus.done      = done_q;
    assign bus.bcd       = bcd_q;
    assign bus.ovf       = ovf_q;
    assign bus.dbg_state = state_q;

endmodule
